// File: rtl/dma_burst_scheduler.sv
// DMA burst scheduler: splits a programmed word-count job into bursts of up to MAX_BEATS beats,
// launching each burst to a DMA master and advancing the addresses as bursts complete.
module dma_burst_scheduler #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_we,
  input  logic [1:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_wdata,
  output logic [31:0] o_cfg_rdata,
  output logic        o_start,
  output logic [31:0] o_source_addr,
  output logic [31:0] o_dest_addr,
  output logic [31:0] o_length,
  input  logic        i_clear_reg,
  output logic        o_busy,
  output logic        o_irq
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StDone} state_e;

  state_e           r_state;
  logic [31:0]      r_src, r_dst, r_len;
  logic [31:0]      r_cur_src, r_cur_dst;
  logic [31:0]      r_source_addr, r_dest_addr, r_length;
  logic [CNT_W-1:0] r_rem, r_chunk;
  logic             r_busy, r_start, r_irq_en, r_done, r_err;

  logic             w_ctrl_wr, w_go, w_w1c;
  logic [CNT_W-1:0] w_chunk;
  logic [31:0]      w_length, w_step;
  logic [15:0]      w_rem16;
  logic [31:0]      w_rdata;

  assign w_ctrl_wr = i_cfg_we && (i_cfg_addr == 2'd3);
  assign w_go      = w_ctrl_wr && i_cfg_wdata[0] && !r_busy;
  assign w_w1c     = w_ctrl_wr && i_cfg_wdata[2];
  assign w_chunk   = (r_rem > CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : r_rem;
  assign w_length  = 32'(w_chunk - CNT_W'(1));
  // Byte advance per completed burst; wraps modulo 2^32 with the address adders.
  assign w_step    = 32'(r_chunk) << 2;
  assign w_rem16   = 16'(r_rem);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_src         <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_cur_src     <= '0;
      r_cur_dst     <= '0;
      r_source_addr <= '0;
      r_dest_addr   <= '0;
      r_length      <= '0;
      r_rem         <= '0;
      r_chunk       <= '0;
      r_busy        <= 1'b0;
      r_start       <= 1'b0;
      r_irq_en      <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (i_cfg_we && !r_busy) begin
        case (i_cfg_addr)
          2'd0:    r_src <= i_cfg_wdata;
          2'd1:    r_dst <= i_cfg_wdata;
          2'd2:    r_len <= i_cfg_wdata;
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= i_cfg_wdata[1];
      if (w_w1c) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      // Flag sets below come after the W1C so a same-cycle set wins.
      case (r_state)
        StIdle: begin
          if (w_go) begin
            r_rem     <= r_len[CNT_W-1:0];
            r_cur_src <= r_src;
            r_cur_dst <= r_dst;
            r_busy    <= 1'b1;
            r_state   <= StCheck;
          end
        end
        StCheck: begin
          r_chunk <= w_chunk;
          if (r_rem == '0) begin
            r_state <= StDone;
          end else if (w_chunk == CNT_W'(1)) begin
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_start       <= 1'b1;
            r_length      <= w_length;
            r_source_addr <= r_cur_src;
            r_dest_addr   <= r_cur_dst;
            r_state       <= StIssue;
          end
        end
        StIssue: r_state <= StWait;
        StWait: begin
          if (i_clear_reg) begin
            r_rem     <= r_rem - r_chunk;
            r_cur_src <= r_cur_src + w_step;
            r_cur_dst <= r_cur_dst + w_step;
            r_state   <= StCheck;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_cfg_addr)
      2'd0:    w_rdata = r_src;
      2'd1:    w_rdata = r_dst;
      2'd2:    w_rdata = r_len;
      default: w_rdata = {w_rem16, 12'd0, r_err, r_done, r_irq_en, r_busy};
    endcase
  end

  assign o_cfg_rdata   = w_rdata;
  assign o_start       = r_start;
  assign o_source_addr = r_source_addr;
  assign o_dest_addr   = r_dest_addr;
  assign o_length      = r_length;
  assign o_busy        = r_busy;
  assign o_irq         = r_done & r_irq_en;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Self-checking bench for dma_burst_scheduler: table-driven jobs with a burst scoreboard,
// plus hand-written timing, W1C-priority, busy-lockout and mid-job reset sequences.
module tb_dma_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        start;
  logic [31:0] src_o, dst_o, len_o;
  logic        clear_reg;
  logic        busy, irq;

  dma_burst_scheduler #(.MAX_BEATS(16), .CNT_W(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cfg_we      (cfg_we),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_wdata   (cfg_wdata),
    .o_cfg_rdata   (cfg_rdata),
    .o_start       (start),
    .o_source_addr (src_o),
    .o_dest_addr   (dst_o),
    .o_length      (len_o),
    .i_clear_reg   (clear_reg),
    .o_busy        (busy),
    .o_irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len;
    logic [31:0] src;
    logic [31:0] dst;
    logic        irq_en;
    int          starts;
    logic        err;
    int          rem;
  } vec_t;

  typedef struct {
    logic [31:0] len;
    logic [31:0] src;
    logic [31:0] dst;
  } burst_t;

  burst_t exp_q[$];
  burst_t mon_b;
  vec_t   vecs[10];
  int     checks = 0;
  int     errors = 0;
  int     starts_seen = 0;
  logic   prev_start = 1'b0;
  logic   auto_clr = 1'b1;
  int     clr_dly = 1;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1 d = cfg_rdata;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (busy && n < budget);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Reference burst list for a job: chunks of min(rem,16), abort on a 1-word chunk.
  task automatic push_job(input logic [31:0] len, input logic [31:0] src, input logic [31:0] dst);
    int unsigned r, c;
    logic [31:0] s, d;
    burst_t b;
    r = {16'd0, len[15:0]};
    s = src;
    d = dst;
    while (r != 0) begin
      c = (r > 32'd16) ? 32'd16 : r;
      if (c == 1) break;
      b.len = 32'(c - 1);
      b.src = s;
      b.dst = d;
      exp_q.push_back(b);
      r = r - c;
      s = s + 32'(c * 4);
      d = d + 32'(c * 4);
    end
  endtask

  // Scoreboard: every start pulse must match the next expected burst and last one cycle.
  always @(negedge clk) begin
    if (start) begin
      starts_seen++;
      check("start_pulse_width", 32'(prev_start), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got start len=%0d src=0x%08h, expected none", len_o, src_o);
      end else begin
        mon_b = exp_q.pop_front();
        check("burst_length", len_o, mon_b.len);
        check("burst_src", src_o, mon_b.src);
        check("burst_dst", dst_o, mon_b.dst);
      end
    end
    prev_start = start;
  end

  // DMA master model: completes each burst clr_dly cycles after its start pulse.
  initial begin
    clear_reg = 1'b0;
    forever begin
      @(negedge clk);
      if (start && auto_clr) begin
        repeat (clr_dly) @(negedge clk);
        clear_reg = 1'b1;
        @(negedge clk);
        clear_reg = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'd16, 32'h1000, 32'h2000, 1'b0, 1, 1'b0, 0};
    vecs[1] = '{32'd40, 32'h1000, 32'h2000, 1'b1, 3, 1'b0, 0};
    vecs[2] = '{32'd0, 32'h1000, 32'h2000, 1'b0, 0, 1'b0, 0};
    vecs[3] = '{32'd17, 32'h1000, 32'h2000, 1'b0, 1, 1'b1, 1};
    vecs[4] = '{32'd1, 32'h3000, 32'h4000, 1'b1, 0, 1'b1, 1};
    vecs[5] = '{32'd34, 32'h5004, 32'h6008, 1'b0, 3, 1'b0, 0};
    vecs[6] = '{32'd2, 32'h10, 32'h20, 1'b1, 1, 1'b0, 0};
    vecs[7] = '{32'd33, 32'h100, 32'h200, 1'b1, 2, 1'b1, 1};
    vecs[8] = '{32'd32, 32'hFFFF_FFC0, 32'hFFFF_FFF0, 1'b0, 2, 1'b0, 0};
    vecs[9] = '{32'h0001_0010, 32'h8000, 32'h9000, 1'b1, 1, 1'b0, 0};

    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 2'd0;
    cfg_wdata = '0;
    repeat (3) step();
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_src_out", src_o, 32'd0);
    check("rst_dst_out", dst_o, 32'd0);
    check("rst_len_out", len_o, 32'd0);
    cfg_read(2'd3, rd);
    check("rst_stat", rd, 32'd0);
    cfg_read(2'd2, rd);
    check("rst_len_reg", rd, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      clr_dly = 1 + (i % 3);
      cfg_write(2'd3, {29'd0, 1'b1, vecs[i].irq_en, 1'b0});
      cfg_write(2'd0, vecs[i].src);
      cfg_write(2'd1, vecs[i].dst);
      cfg_write(2'd2, vecs[i].len);
      push_job(vecs[i].len, vecs[i].src, vecs[i].dst);
      starts_seen = 0;
      cfg_write(2'd3, {30'd0, vecs[i].irq_en, 1'b1});
      check($sformatf("v%0d_busy_after_go", i), 32'(busy), 32'd1);
      wait_idle(400);
      step();
      check($sformatf("v%0d_starts", i), 32'(starts_seen), 32'(vecs[i].starts));
      check($sformatf("v%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
      cfg_read(2'd3, rd);
      check($sformatf("v%0d_done", i), 32'(rd[2]), 32'd1);
      check($sformatf("v%0d_err", i), 32'(rd[3]), 32'(vecs[i].err));
      check($sformatf("v%0d_rem", i), 32'(rd[31:16]), 32'(vecs[i].rem));
      check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].irq_en));
      exp_q.delete();
    end

    // LEN=0: done appears three cycles after the go write; then set-over-W1C priority.
    cfg_write(2'd3, 32'h4);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd3, 32'h1);
    step();
    cfg_read(2'd3, rd);
    check("len0_done_early", 32'(rd[2]), 32'd0);
    check("len0_busy_early", 32'(busy), 32'd1);
    step();
    cfg_read(2'd3, rd);
    check("len0_done", 32'(rd[2]), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_rem", 32'(rd[31:16]), 32'd0);
    cfg_write(2'd3, 32'h4);
    cfg_read(2'd3, rd);
    check("w1c_clears_done", 32'(rd[2]), 32'd0);
    cfg_write(2'd3, 32'h1);
    cfg_write(2'd3, 32'h4);
    cfg_read(2'd3, rd);
    check("done_set_beats_w1c", 32'(rd[2]), 32'd1);

    // Writes while busy are ignored; irq_en still updates; clear->start gap is two cycles.
    cfg_write(2'd3, 32'h4);
    cfg_write(2'd0, 32'h1000);
    cfg_write(2'd1, 32'h2000);
    cfg_write(2'd2, 32'd40);
    push_job(32'd40, 32'h1000, 32'h2000);
    starts_seen = 0;
    auto_clr = 1'b0;
    cfg_write(2'd3, 32'h1);
    check("go_start_latency_early", 32'(start), 32'd0);
    step();
    check("go_start_latency", 32'(start), 32'd1);
    step();
    step();
    cfg_write(2'd0, 32'hDEAD_0000);
    cfg_write(2'd3, 32'h3);
    check("busy_src_out_held", src_o, 32'h1000);
    cfg_read(2'd0, rd);
    check("busy_src_write_ignored", rd, 32'h1000);
    check("busy_go_no_start", 32'(start), 32'd0);
    clear_reg = 1'b1;
    step();
    clear_reg = 1'b0;
    check("clear_start_gap", 32'(start), 32'd0);
    auto_clr = 1'b1;
    step();
    check("clear_start_latency", 32'(start), 32'd1);
    wait_idle(400);
    step();
    check("busy_job_starts", 32'(starts_seen), 32'd3);
    check("irq_en_set_while_busy", 32'(irq), 32'd1);
    cfg_write(2'd3, 32'h6);
    check("w1c_irq_low", 32'(irq), 32'd0);
    cfg_read(2'd3, rd);
    check("w1c_keeps_irq_en", 32'(rd[1]), 32'd1);
    exp_q.delete();

    // Reset during WAIT abandons the job; a later clear_reg does nothing.
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd3, 32'h3);
    wait_idle(50);
    cfg_write(2'd2, 32'd40);
    push_job(32'd40, 32'h1000, 32'h2000);
    auto_clr = 1'b0;
    cfg_write(2'd3, 32'h3);
    step();
    step();
    step();
    check("pre_rst_irq", 32'(irq), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(start), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    clear_reg = 1'b1;
    step();
    clear_reg = 1'b0;
    repeat (5) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_src_out", src_o, 32'd0);
    check("post_rst_len_out", len_o, 32'd0);
    cfg_read(2'd3, rd);
    check("post_rst_stat", rd, 32'd0);
    cfg_read(2'd0, rd);
    check("post_rst_src_reg", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
